solution_serializer: RTL and testbench
======================================

// Module: solution_serializer
// PURPOSE
//  Downstream of the solver: snapshots the solved board bit-vector plus its dimensions, then
//  streams it byte-by-byte into uart_tx through a pulse/busy handshake. Frame: one header byte,
//  the packed rows, then an optional checksum byte. Pulses done once the last byte has left the UART.
// PARAMETERS
//  MAX_ROWS  11  max board rows; row index width RW = $clog2(MAX_ROWS)
//  MAX_COLS  11  max board cols; col index width CW = $clog2(MAX_COLS)
// PORTS
//  clk_100mhz      in   1                    system clock
//  rst             in   1                    async active-high reset
//  valid_in        in   1                    1-cycle pulse: solution/m/n are valid, start a frame
//  solution        in   MAX_ROWS*MAX_COLS    cell (r,c) = solution[r*MAX_COLS+c]; 1 = filled
//  m               in   RW                   rows in use, 0..MAX_ROWS
//  n               in   CW                   cols in use, 0..MAX_COLS
//  transmit_busy   in   1                    high while uart_tx is shifting a byte
//  transmit_ready  out  1                    1-cycle pulse: byte_out is valid, start sending it
//  byte_out        out  8                    byte to transmit
//  busy            out  1                    high from accepted valid_in until done
//  done            out  1                    1-cycle pulse after the final byte completes
// BEHAVIOUR
//  - Clock and reset: one clock, clk_100mhz. rst is asynchronous and active-high.
//    Reset state: IDLE; all outputs 0; internal snapshot cleared.
//  - A rst assertion at any time (mid-frame included) aborts at once. No partial done is issued.
//  - States:
//    IDLE -> LOAD on valid_in.
//    LOAD (1 cycle): register solution, m, n; row=0, chunk=0; clear checksum; emit_hdr=1.
//    SEND: if !transmit_busy, present the byte, pulse transmit_ready, go to WAIT_ACK.
//          If transmit_busy is high, stall in SEND.
//    WAIT_ACK: wait for transmit_busy=1, then go to WAIT_DONE.
//    WAIT_DONE: wait for transmit_busy=0. Advance the pointer. Go to SEND if bytes remain, else DONE.
//    DONE (1 cycle): pulse done, go to IDLE.
//  - byte_out is stable from the transmit_ready cycle until the WAIT_DONE exit.
//  - Byte order:
//    header = {m[3:0], n[3:0]}, zero-extended/truncated to 4 bits each.
//    For each row r = 0..m-1: CH = ceil(n/8) chunk bytes.
//    Chunk k bit b = cell (r, 8k+b) if 8k+b < n, else 0 (LSB = leftmost column).
//  - Frame length = 1 + m*CH (+1 with checksum).
//    m=0 or n=0: header only.
//    m or n above MAX_*: clamp to MAX_* internally; the header still carries the raw value.
//  - valid_in while busy=1: ignored. The snapshot is not disturbed.
//    valid_in on the DONE cycle: ignored.
//  - Latency: valid_in to first transmit_ready = 2 cycles when transmit_busy is low.
//  - Counters: row counter is RW+1 bits; chunk counter is 1 bit (CH <= 2 for MAX_COLS <= 16).
//    No wrap is permitted; end of frame is detected by compare, not by overflow.
// CONFIGURATION
//  SERIALIZER_CHECKSUM_EN defined:
//    Running XOR of every sent byte, header included, is updated on each WAIT_DONE exit.
//    It is appended as the final byte.
//  SERIALIZER_CHECKSUM_EN undefined:
//    No checksum register or byte; the frame ends after the last row chunk.
// TESTING
//  1. rst pulsed mid-SEND of an 11x11 frame -> outputs 0 at once; next valid_in gives a clean full frame.
//  2. 11x11, all cells 1, busy model 3 cycles/byte -> 23 bytes:
//     0xBB, then 11 x {0xFF, 0x07}; done pulses once.
//  3. 2x3, solution rows 101/010 -> bytes 0x23, 0x05, 0x02.
//     With SERIALIZER_CHECKSUM_EN, add 0x24.
//  4. m=0, n=5 -> single byte 0x05, then done.
//     With checksum: 0x05, 0x05.
//  5. Hold transmit_busy=1 for 50 cycles at start -> no transmit_ready until busy falls;
//     a second valid_in during the frame -> ignored, byte stream unchanged.
//  6. Checker: transmit_ready never asserts while transmit_busy=1;
//     byte_out is constant from transmit_ready through busy fall.

Source files
------------

// File: rtl/solution_serializer.sv
// rtl/solution_serializer.sv - snapshot a solved board and stream header/rows over a uart_tx pulse/busy handshake
// Optional trailing XOR checksum byte: define SERIALIZER_CHECKSUM_EN.
module solution_serializer #(
  parameter int MAX_ROWS = 11,
  parameter int MAX_COLS = 11,
  localparam int RW = $clog2(MAX_ROWS),
  localparam int CW = $clog2(MAX_COLS)
) (
  input  logic                         clk_100mhz,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [MAX_ROWS*MAX_COLS-1:0] solution,
  input  logic [RW-1:0]                m,
  input  logic [CW-1:0]                n,
  input  logic                         transmit_busy,
  output logic                         transmit_ready,
  output logic [7:0]                   byte_out,
  output logic                         busy,
  output logic                         done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_WAIT_ACK, S_WAIT_DONE, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [MAX_ROWS*MAX_COLS-1:0] sol_r;
  logic [RW-1:0]                m_r;
  logic [CW-1:0]                n_r;
  logic [RW:0]                  row;
  logic [RW:0]                  m_eff;
  logic [CW:0]                  n_eff;
  logic                         chunk;
  logic                         ch_last;
  logic                         emit_hdr;
  logic [7:0]                   byte_r;
  logic                         tr_r;
  logic [7:0]                   hdr_byte;
  logic [7:0]                   data_byte;
  logic [7:0]                   cur_byte;
  logic [MAX_COLS-1:0]          row_cells;
  logic [MAX_COLS-1:0]          col_mask;
  logic [15:0]                  row_padded;
  logic                         hdr_only;
  logic                         chunk_last;
  logic                         data_last;
  logic                         frame_last;
`ifdef SERIALIZER_CHECKSUM_EN
  logic                         emit_ck;
  logic [7:0]                   csum;
`endif

  // Oversized dimensions are clamped for traversal; the header keeps the raw values.
  always_comb begin
    m_eff = ({1'b0, m_r} > (RW+1)'(MAX_ROWS)) ? (RW+1)'(MAX_ROWS) : {1'b0, m_r};
    n_eff = ({1'b0, n_r} > (CW+1)'(MAX_COLS)) ? (CW+1)'(MAX_COLS) : {1'b0, n_r};
    ch_last  = (n_eff > (CW+1)'(8));
    hdr_only = (m_eff == '0) || (n_eff == '0);
    hdr_byte = {4'(m_r), 4'(n_r)};
  end

  always_comb begin
    col_mask = '0;
    for (int c = 0; c < MAX_COLS; c++) begin
      col_mask[c] = (c < int'(n_eff));
    end
    row_cells  = MAX_COLS'(sol_r >> (int'(row) * MAX_COLS));
    row_padded = 16'(row_cells & col_mask);
    data_byte  = chunk ? row_padded[15:8] : row_padded[7:0];
    chunk_last = (chunk == ch_last);
    data_last  = chunk_last && ((row + (RW+1)'(1)) == m_eff);
  end

  always_comb begin
    cur_byte   = data_byte;
    frame_last = emit_hdr ? hdr_only : data_last;
`ifdef SERIALIZER_CHECKSUM_EN
    if (emit_ck) begin
      cur_byte = csum;
    end
    frame_last = emit_ck;
`endif
    if (emit_hdr) begin
      cur_byte = hdr_byte;
    end
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (valid_in) state_nxt = S_LOAD;
      S_LOAD:      state_nxt = S_SEND;
      S_SEND:      if (!transmit_busy) state_nxt = S_WAIT_ACK;
      S_WAIT_ACK:  if (transmit_busy) state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (!transmit_busy) state_nxt = frame_last ? S_DONE : S_SEND;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Snapshot is taken only on an accepted valid_in, so requests while busy cannot disturb it.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      sol_r    <= '0;
      m_r      <= '0;
      n_r      <= '0;
      row      <= '0;
      chunk    <= 1'b0;
      emit_hdr <= 1'b0;
      byte_r   <= 8'h00;
      tr_r     <= 1'b0;
`ifdef SERIALIZER_CHECKSUM_EN
      emit_ck  <= 1'b0;
      csum     <= 8'h00;
`endif
    end else begin
      tr_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_in) begin
            sol_r <= solution;
            m_r   <= m;
            n_r   <= n;
          end
        end
        S_LOAD: begin
          row      <= '0;
          chunk    <= 1'b0;
          emit_hdr <= 1'b1;
`ifdef SERIALIZER_CHECKSUM_EN
          emit_ck  <= 1'b0;
          csum     <= 8'h00;
`endif
        end
        S_SEND: begin
          if (!transmit_busy) begin
            byte_r <= cur_byte;
            tr_r   <= 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!transmit_busy) begin
`ifdef SERIALIZER_CHECKSUM_EN
            csum <= csum ^ byte_r;
            if (emit_hdr) begin
              emit_hdr <= 1'b0;
              if (hdr_only) emit_ck <= 1'b1;
            end else if (!emit_ck) begin
              if (chunk_last) begin
                chunk <= 1'b0;
                row   <= row + (RW+1)'(1);
                if (data_last) emit_ck <= 1'b1;
              end else begin
                chunk <= 1'b1;
              end
            end
`else
            if (emit_hdr) begin
              emit_hdr <= 1'b0;
            end else if (chunk_last) begin
              chunk <= 1'b0;
              row   <= row + (RW+1)'(1);
            end else begin
              chunk <= 1'b1;
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign transmit_ready = tr_r;
  assign byte_out       = byte_r;
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);

endmodule

// File: tb/tb_solution_serializer.sv
// tb/tb_solution_serializer.sv - directed + randomized bench for solution_serializer against a frame-level model
module tb_solution_serializer;

  logic         clk_100mhz;
  logic         rst;
  logic         valid_in;
  logic [120:0] solution;
  logic [3:0]   m;
  logic [3:0]   n;
  logic         transmit_busy;
  logic         transmit_ready;
  logic [7:0]   byte_out;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int done_cnt = 0;
  int uart_cycles = 3;
  logic force_busy = 1'b0;

  solution_serializer dut (
    .clk_100mhz    (clk_100mhz),
    .rst           (rst),
    .valid_in      (valid_in),
    .solution      (solution),
    .m             (m),
    .n             (n),
    .transmit_busy (transmit_busy),
    .transmit_ready(transmit_ready),
    .byte_out      (byte_out),
    .busy          (busy),
    .done          (done)
  );

  initial begin
    clk_100mhz = 1'b0;
    forever #5 clk_100mhz = ~clk_100mhz;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART stand-in: captures each byte and stays busy for uart_cycles cycles.
  initial begin
    int busy_cnt;
    logic [7:0] held;
    busy_cnt = 0;
    held = 8'h00;
    transmit_busy = 1'b0;
    forever begin
      @(negedge clk_100mhz);
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (done) done_cnt++;
        if (transmit_ready) begin
          check("ready_while_busy", {31'd0, transmit_busy}, 32'd0);
          rx_q.push_back(byte_out);
          held = byte_out;
          busy_cnt = uart_cycles;
        end else if (busy_cnt > 0) begin
          check("byte_out_stable", {24'd0, byte_out}, {24'd0, held});
          busy_cnt--;
        end
      end
      transmit_busy = force_busy || (busy_cnt > 0);
    end
  end

  task automatic model(input logic [120:0] s, input logic [3:0] mm, input logic [3:0] nn);
    int rows;
    int cols;
    logic [7:0] b;
    logic [7:0] ck;
    exp_q.delete();
    rows = (mm > 4'd11) ? 11 : int'(mm);
    cols = (nn > 4'd11) ? 11 : int'(nn);
    exp_q.push_back({mm, nn});
    ck = {mm, nn};
    if (rows > 0 && cols > 0) begin
      for (int r = 0; r < rows; r++) begin
        for (int k = 0; k < (cols + 7) / 8; k++) begin
          b = 8'h00;
          for (int bi = 0; bi < 8; bi++) begin
            if (8 * k + bi < cols) b[bi] = s[r * 11 + 8 * k + bi];
          end
          exp_q.push_back(b);
          ck = ck ^ b;
        end
      end
    end
`ifdef SERIALIZER_CHECKSUM_EN
    exp_q.push_back(ck);
`endif
  endtask

  task automatic start_frame(input logic [120:0] s, input logic [3:0] mm, input logic [3:0] nn);
    @(negedge clk_100mhz);
    solution = s;
    m = mm;
    n = nn;
    model(s, mm, nn);
    rx_q.delete();
    done_cnt = 0;
    valid_in = 1'b1;
    @(negedge clk_100mhz);
    valid_in = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    int cyc;
    cyc = 0;
    while (busy && cyc < 5000) begin
      @(negedge clk_100mhz);
      cyc++;
    end
    check({tag, "_timeout"}, {31'd0, busy}, 32'd0);
    @(negedge clk_100mhz);
    check({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    end
    check({tag, "_done_once"}, done_cnt, 1);
  endtask

  initial begin
    logic [120:0] s;
    logic [120:0] ones;
    logic [3:0]   rm;
    logic [3:0]   rn;
    ones = '1;
    rst = 1'b1;
    valid_in = 1'b0;
    solution = '0;
    m = 4'd0;
    n = 4'd0;

    repeat (3) @(negedge clk_100mhz);
    check("rst_ready", {31'd0, transmit_ready}, 32'd0);
    check("rst_byte", {24'd0, byte_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    // 2x3 rows 101 / 010, with first-byte latency check
    uart_cycles = 3;
    s = '0;
    s[0] = 1'b1;
    s[2] = 1'b1;
    s[12] = 1'b1;
    start_frame(s, 4'd2, 4'd3);
    @(negedge clk_100mhz);
    check("lat_cycle1", {31'd0, transmit_ready}, 32'd0);
    @(negedge clk_100mhz);
    check("lat_cycle2", {31'd0, transmit_ready}, 32'd1);
    check("lat_byte", {24'd0, byte_out}, 32'h23);
    finish_frame("f2x3");
    if (rx_q.size() >= 3) begin
      check("f2x3_c0", {24'd0, rx_q[0]}, 32'h23);
      check("f2x3_c1", {24'd0, rx_q[1]}, 32'h05);
      check("f2x3_c2", {24'd0, rx_q[2]}, 32'h02);
    end

    // reset in the middle of an 11x11 frame
    start_frame(ones, 4'd11, 4'd11);
    repeat (20) @(negedge clk_100mhz);
    #2 rst = 1'b1;
    #1;
    check("abort_ready", {31'd0, transmit_ready}, 32'd0);
    check("abort_byte", {24'd0, byte_out}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk_100mhz);
    rst = 1'b0;
    check("abort_no_done", done_cnt, 0);

    // full 11x11 all-ones frame
    start_frame(ones, 4'd11, 4'd11);
    finish_frame("f11");
`ifdef SERIALIZER_CHECKSUM_EN
    check("f11_len_const", rx_q.size(), 24);
`else
    check("f11_len_const", rx_q.size(), 23);
`endif
    if (rx_q.size() >= 3) begin
      check("f11_hdr", {24'd0, rx_q[0]}, 32'hBB);
      check("f11_c0", {24'd0, rx_q[1]}, 32'hFF);
      check("f11_c1", {24'd0, rx_q[2]}, 32'h07);
    end

    // header-only frame
    uart_cycles = 1;
    start_frame(121'($urandom), 4'd0, 4'd5);
    finish_frame("f0x5");
    if (rx_q.size() >= 1) check("f0x5_hdr", {24'd0, rx_q[0]}, 32'h05);

    // UART busy at start, plus an ignored valid_in mid-frame
    uart_cycles = 2;
    force_busy = 1'b1;
    @(negedge clk_100mhz);
    s = 121'({$urandom, $urandom, $urandom, $urandom});
    start_frame(s, 4'd7, 4'd10);
    repeat (50) @(negedge clk_100mhz);
    check("stall_no_bytes", rx_q.size(), 0);
    force_busy = 1'b0;
    repeat (12) @(negedge clk_100mhz);
    solution = ~s;
    m = 4'd3;
    n = 4'd2;
    valid_in = 1'b1;
    @(negedge clk_100mhz);
    valid_in = 1'b0;
    finish_frame("fstall");

    // randomized frames, including dimensions above 11
    for (int t = 0; t < 8; t++) begin
      uart_cycles = $urandom_range(1, 4);
      s = 121'({$urandom, $urandom, $urandom, $urandom});
      rm = 4'($urandom_range(0, 15));
      rn = 4'($urandom_range(0, 15));
      start_frame(s, rm, rn);
      finish_frame($sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
